// File: rtl/ram_sdp_be_clr.sv
// Simple dual-port RAM: byte-enabled write port, registered read port with valid flag,
// selectable read-during-write result, and a clear engine that zeroes every word.
module ram_sdp_be_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   d,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   q_reg;
    logic                    rd_valid_reg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_go;
    logic                    rd_go;
    logic [NB-1:0]           lane_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign busy     = (state_reg == CLEAR);
    assign q        = q_reg;
    assign rd_valid = rd_valid_reg;

    // clr outranks any access requested in the same cycle
    assign wr_go = (state_reg == IDLE) && !clr && we;
    assign rd_go = (state_reg == IDLE) && !clr && re;

    // The clear engine borrows the write port while busy
    assign mem_waddr = busy ? cnt_reg : wr_addr;
    assign mem_wdata = busy ? '0 : d;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane_we
            assign lane_we[gi] = busy || (wr_go && wr_be[gi]);
        end

        if (RDW_MODE == 1) begin : g_rdw_new
            logic collide;
            assign collide = wr_go && (wr_addr == rd_addr);
            for (genvar gi = 0; gi < NB; gi++) begin : g_merge
                assign rd_word[8*gi +: 8] = (collide && wr_be[gi]) ? d[8*gi +: 8]
                                                                   : mem[rd_addr][8*gi +: 8];
            end
        end else begin : g_rdw_old
            assign rd_word = mem[rd_addr];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                cnt_next = cnt_reg + ADDR_WIDTH'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Array has no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg        <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_go;
            if (rd_go) begin
                q_reg <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Bench for ram_sdp_be_clr: two 32x128 instances (old-data and new-data collision modes)
// share stimulus against an array model; a 16x16 instance covers the narrow configuration.
module tb_ram_sdp_be_clr;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr, we, re;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [3:0]    wr_be;
    logic [DW-1:0] d;
    logic [DW-1:0] q0, q1;
    logic          rv0, rv1, busy0, busy1;

    logic          s_rst, s_clr, s_we, s_re;
    logic [3:0]    s_wr_addr, s_rd_addr;
    logic [1:0]    s_wr_be;
    logic [15:0]   s_d, s_q;
    logic          s_rv, s_busy;

    ram_sdp_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy0), .we(we), .wr_addr(wr_addr),
        .wr_be(wr_be), .d(d), .re(re), .rd_addr(rd_addr), .q(q0), .rd_valid(rv0));

    ram_sdp_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1), .we(we), .wr_addr(wr_addr),
        .wr_be(wr_be), .d(d), .re(re), .rd_addr(rd_addr), .q(q1), .rd_valid(rv1));

    ram_sdp_be_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0)) dut_s (
        .clk(clk), .rst(s_rst), .clr(s_clr), .busy(s_busy), .we(s_we), .wr_addr(s_wr_addr),
        .wr_be(s_wr_be), .d(s_d), .re(s_re), .rd_addr(s_rd_addr), .q(s_q), .rd_valid(s_rv));

    int checks = 0;
    int errors = 0;

    // Reference model: word array plus remaining clear edges
    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy_left;
    logic [DW-1:0] m_q0, m_q1;
    logic          m_rv;

    task automatic model_reset();
        m_busy_left = DEPTH;
        m_q0 = '0;
        m_q1 = '0;
        m_rv = 1'b0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_word;
        if (m_busy_left > 0) begin
            m_mem[DEPTH - m_busy_left] = '0;
            m_busy_left--;
            m_rv = 1'b0;
        end else if (clr) begin
            m_busy_left = DEPTH;
            m_rv = 1'b0;
        end else begin
            old_word = m_mem[rd_addr];
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) m_mem[wr_addr][8*b +: 8] = d[8*b +: 8];
                end
            end
            m_rv = re;
            if (re) begin
                m_q0 = old_word;
                m_q1 = m_mem[rd_addr];
            end
        end
    endtask

    task automatic cycle(input logic we_i, input logic [AW-1:0] wa, input logic [3:0] be,
                         input logic [DW-1:0] dd, input logic re_i, input logic [AW-1:0] ra,
                         input logic clr_i);
        we = we_i; wr_addr = wa; wr_be = be; d = dd; re = re_i; rd_addr = ra; clr = clr_i;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 4'h0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q0 !== 32'h0 || rv0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: q=%h rv=%b busy=%b, need q=0 rv=0 busy=1", q0, rv0, busy0);
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            checks++;
            if (busy0 !== (m_busy_left > 0) || busy1 !== (m_busy_left > 0)) begin
                errors++;
                $display("FAIL reset_busy edge %0d: busy0=%b busy1=%b need %b", i + 1, busy0, busy1, m_busy_left > 0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            logic [AW-1:0] a;
            a = (k == 0) ? 7'd0 : (k == 1) ? 7'd64 : 7'd127;
            cycle(1'b0, '0, 4'h0, '0, 1'b1, a, 1'b0);
            checks++;
            if (q0 !== 32'h0 || rv0 !== 1'b1 || q1 !== 32'h0 || rv1 !== 1'b1) begin
                errors++;
                $display("FAIL reset_read addr %0d: q0=%h rv0=%b q1=%h rv1=%b need 0/1", a, q0, rv0, q1, rv1);
            end
            idle();
            checks++;
            if (rv0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_rv_pulse addr %0d: rv=%b need 0", a, rv0);
            end
        end
    endtask

    task automatic test_byte_enables();
        cycle(1'b1, 7'd3, 4'b1111, 32'hAABBCCDD, 1'b0, '0, 1'b0);
        cycle(1'b1, 7'd3, 4'b0101, 32'h11223344, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 4'h0, '0, 1'b1, 7'd3, 1'b0);
        checks++;
        if (q0 !== 32'hAA22CC44 || q0 !== m_q0 || rv0 !== 1'b1) begin
            errors++;
            $display("FAIL byte_en: q=%h rv=%b need %h rv=1", q0, rv0, 32'hAA22CC44);
        end
        cycle(1'b1, 7'd3, 4'b0000, 32'hFFFFFFFF, 1'b1, 7'd3, 1'b0);
        cycle(1'b0, '0, 4'h0, '0, 1'b1, 7'd3, 1'b0);
        checks++;
        if (q0 !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL byte_en_none: q=%h need %h", q0, 32'hAA22CC44);
        end
    endtask

    task automatic test_collision();
        cycle(1'b1, 7'd7, 4'b1111, 32'h1, 1'b0, '0, 1'b0);
        cycle(1'b1, 7'd7, 4'b1111, 32'h2, 1'b1, 7'd7, 1'b0);
        checks++;
        if (q0 !== 32'h1 || q1 !== 32'h2) begin
            errors++;
            $display("FAIL collision: q_old=%h q_new=%h need 1 and 2", q0, q1);
        end
        cycle(1'b0, '0, 4'h0, '0, 1'b1, 7'd7, 1'b0);
        checks++;
        if (q0 !== 32'h2 || q1 !== 32'h2) begin
            errors++;
            $display("FAIL collision_after: q_old=%h q_new=%h need 2", q0, q1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) cycle(1'b1, AW'(40 + i), 4'hF, 32'hC0DE0000 + i, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 4'h0, '0, 1'b1, AW'(40 + i), 1'b0);
            checks++;
            if (rv0 !== 1'b1 || q0 !== 32'hC0DE0000 + i) begin
                errors++;
                $display("FAIL b2b read %0d: q=%h rv=%b need %h rv=1", i, q0, rv0, 32'hC0DE0000 + i);
            end
        end
    endtask

    task automatic test_clr_use();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, AW'(i), 4'hF, 32'(i + 1), 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 4'h0, '0, 1'b1, 7'd5, 1'b0);
        cycle(1'b1, 7'd9, 4'hF, 32'hDEADBEEF, 1'b1, 7'd9, 1'b1);
        checks++;
        if (busy0 !== 1'b1 || rv0 !== 1'b0 || q0 !== 32'd6) begin
            errors++;
            $display("FAIL clr_start: busy=%b rv=%b q=%h need 1 0 6", busy0, rv0, q0);
        end
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b1, AW'($urandom), 4'hF, $urandom, 1'b1, AW'($urandom), 1'b1);
            checks++;
            if (busy0 !== (m_busy_left > 0) || rv0 !== 1'b0 || q0 !== m_q0) begin
                errors++;
                $display("FAIL clr_busy edge %0d: busy=%b rv=%b q=%h need %b 0 %h", i, busy0, rv0, q0, m_busy_left > 0, m_q0);
            end
        end
        idle();
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_end: busy=%b need 0", busy0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 4'h0, '0, 1'b1, AW'(i), 1'b0);
            checks++;
            if (q0 !== 32'h0 || rv0 !== 1'b1) begin
                errors++;
                $display("FAIL clr_read addr %0d: q=%h rv=%b need 0 rv=1", i, q0, rv0);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        cycle(1'b1, 7'd20, 4'hF, 32'h12345678, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 4'h0, '0, 1'b1, 7'd20, 1'b0);
        cycle(1'b0, '0, 4'h0, '0, 1'b0, '0, 1'b1);
        repeat (50) idle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (q0 !== 32'h0 || rv0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midclr_rst: q=%h rv=%b busy=%b need 0 0 1", q0, rv0, busy0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            idle();
            n++;
            if (!busy0) break;
        end
        checks++;
        if (n !== DEPTH || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midclr_len: busy edges=%0d busy=%b need %0d", n, busy0, DEPTH);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] wa, ra;
        for (int i = 0; i < 800; i++) begin
            wa = AW'($urandom_range(0, 15));
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 15));
            cycle($urandom_range(0, 1) == 1, wa, 4'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, ra, $urandom_range(0, 299) == 0);
            checks++;
            if (q0 !== m_q0 || q1 !== m_q1 || rv0 !== m_rv || rv1 !== m_rv || busy0 !== (m_busy_left > 0)) begin
                errors++;
                $display("FAIL random cyc %0d: q0=%h/%h q1=%h/%h rv=%b/%b busy=%b/%b", i,
                         q0, m_q0, q1, m_q1, rv0, m_rv, busy0, m_busy_left > 0);
            end
        end
    endtask

    task automatic test_param_sweep();
        int n;
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_busy !== 1'b1 || s_rv !== 1'b0 || s_q !== 16'h0) begin
            errors++;
            $display("FAIL sweep_rst: busy=%b rv=%b q=%h need 1 0 0", s_busy, s_rv, s_q);
        end
        s_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!s_busy) break;
        end
        checks++;
        if (n !== 16 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_busy: busy edges=%0d busy=%b need 16", n, s_busy);
        end
        s_we = 1'b1; s_wr_addr = 4'd15; s_wr_be = 2'b10; s_d = 16'hBEEF;
        @(posedge clk);
        #1;
        s_we = 1'b0; s_re = 1'b1; s_rd_addr = 4'd15;
        @(posedge clk);
        #1;
        s_re = 1'b0;
        checks++;
        if (s_q !== 16'hBE00 || s_rv !== 1'b1) begin
            errors++;
            $display("FAIL sweep_read: q=%h rv=%b need BE00 rv=1", s_q, s_rv);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; d = '0;
        s_rst = 1'b1; s_clr = 1'b0; s_we = 1'b0; s_re = 1'b0;
        s_wr_addr = '0; s_rd_addr = '0; s_wr_be = '0; s_d = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        test_reset();
        test_byte_enables();
        test_collision();
        test_back_to_back();
        test_clr_use();
        test_reset_mid_clear();
        test_random();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
